// File: rtl/spi_voice_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_voice_cmd_decoder
//
// SPI slave (mode 0, MSB first) that receives voice command frames from the
// host MCU. It turns each complete frame into an atomic update of the
// per-voice parameter bus and a one-cycle strobe for voice_controller.
// Tuning writes raise o_SPI_flag_dds. Note on/off raises o_SPI_flag_adsr.
//
// Frames (command byte first, then payload):
//   0x01 SET_TUNING : voice, tune[31:24], tune[23:16], tune[15:8], tune[7:0]
//   0x02 NOTE_ON    : voice, velocity (bit 7 ignored)
//   0x03 NOTE_OFF   : voice
//   any other command byte is counted as an error; the rest of the frame
//   is discarded.
//
// Ports
//   i_clk              system clock (SCLK must be <= i_clk/8)
//   i_reset_n          synchronous active-low reset
//   i_sclk/i_mosi/i_cs_n  asynchronous SPI inputs, synchronised internally
//   o_SPI_note_status  1 = note on, 0 = note off (meaningful with flag_adsr)
//   o_SPI_voice_index  target voice
//   o_SPI_tuning_code  DDS phase increment (meaningful with flag_dds)
//   o_SPI_velocity     note-on velocity
//   o_SPI_flag_dds     one-cycle strobe: tuning write committed
//   o_SPI_flag_adsr    one-cycle strobe: note on/off committed
//   o_err_count        saturating count of aborted and unknown frames
//   o_dbg_state        current decoder FSM state, for observation only
//
// Output handshake: there is no back-pressure. The data fields are registered
// and change only in the same cycle a flag rises. The consumer must take the
// fields in the single cycle the flag is high. At most one flag is high per
// cycle. Between strobes, every field holds its last committed value.
// -----------------------------------------------------------------------------
module spi_voice_cmd_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_sclk,
    input  logic        i_mosi,
    input  logic        i_cs_n,
    output logic        o_SPI_note_status,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [6:0]  o_SPI_velocity,
    output logic        o_SPI_flag_dds,
    output logic        o_SPI_flag_adsr,
    output logic [7:0]  o_err_count,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    // Command codes are stored as their low two bits once validated.
    localparam logic [1:0] CMD_SET_TUNING = 2'd1;
    localparam logic [1:0] CMD_NOTE_ON    = 2'd2;

    // Index of the final payload byte for each command.
    function automatic logic [2:0] last_index(input logic [1:0] cmd);
        case (cmd)
            2'd1:    return 3'd4;
            2'd2:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // ---------------- synchroniser and edge detect ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, cs_rise, cs_fall, sample;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    // A bit is still taken when sclk rises in the same cycle cs_n is seen
    // going high, so a frame whose last edge races the release still lands.
    assign sample    = sclk_rise & (~cs_s | ~cs_prev_q);

    // ---------------- byte assembly ----------------
    logic [7:0] shift_q,      shift_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic       byte_done_q,  byte_done_d;
    logic       cs_rise_q,    cs_rise_d;
    logic       frame_bits_q, frame_bits_d;
    logic       abort_bits_q, abort_bits_d;

    // ---------------- decoder FSM ----------------
    state_t      state_q,    state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  cmd_q,      cmd_d;
    logic [7:0]  voice_sh_q, voice_sh_d;
    logic [23:0] tune_sh_q,  tune_sh_d;

    logic        note_q,     note_d;
    logic [7:0]  voice_q,    voice_d;
    logic [31:0] tune_q,     tune_d;
    logic [6:0]  vel_q,      vel_d;
    logic        flag_dds_q, flag_dds_d;
    logic        flag_adsr_q, flag_adsr_d;
    logic [7:0]  err_q,      err_d;

    logic cmd_known, commit_now, err_now;

    assign cmd_known = (shift_q == 8'h01) || (shift_q == 8'h02) || (shift_q == 8'h03);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   i_cs_n};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;

        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (sample) begin
            shift_d   = {shift_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (cs_rise) begin
            bit_cnt_d = 3'd0;
        end
        byte_done_d  = sample && (bit_cnt_q == 3'd7);
        // cs_n rise is delayed one cycle so the FSM sees it together with
        // any byte that completed on the same edge.
        cs_rise_d    = cs_rise;
        frame_bits_d = cs_rise ? 1'b0 : (frame_bits_q | sample);
        abort_bits_d = cs_rise & (frame_bits_q | sample);

        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        cmd_d       = cmd_q;
        voice_sh_d  = voice_sh_q;
        tune_sh_d   = tune_sh_q;
        note_d      = note_q;
        voice_d     = voice_q;
        tune_d      = tune_q;
        vel_d       = vel_q;
        flag_dds_d  = 1'b0;
        flag_adsr_d = 1'b0;
        err_d       = err_q;
        commit_now  = 1'b0;
        err_now     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_CMD;
                    byte_cnt_d = 3'd0;
                end
            end
            ST_CMD: begin
                if (byte_done_q) begin
                    if (cmd_known) begin
                        cmd_d      = shift_q[1:0];
                        byte_cnt_d = 3'd0;
                        state_d    = ST_PAYLOAD;
                    end else begin
                        err_now = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_done_q) begin
                    if (byte_cnt_q == 3'd0) begin
                        voice_sh_d = shift_q;
                    end else begin
                        tune_sh_d = {tune_sh_q[15:0], shift_q};
                    end
                    if (byte_cnt_q == last_index(cmd_q)) begin
                        // The final byte is used directly so all fields
                        // update in the same cycle as the strobe.
                        commit_now = 1'b1;
                        state_d    = ST_COMMIT;
                        if (cmd_q == CMD_SET_TUNING) begin
                            voice_d    = voice_sh_q;
                            tune_d     = {tune_sh_q, shift_q};
                            flag_dds_d = 1'b1;
                        end else if (cmd_q == CMD_NOTE_ON) begin
                            voice_d     = voice_sh_q;
                            vel_d       = shift_q[6:0];
                            note_d      = 1'b1;
                            flag_adsr_d = 1'b1;
                        end else begin
                            voice_d     = shift_q;
                            vel_d       = 7'd0;
                            note_d      = 1'b0;
                            flag_adsr_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = cs_s ? ST_IDLE : ST_DISCARD;
            end
            ST_DISCARD: begin
                state_d = ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Release of cs_n ends the frame. An unfinished frame counts as an
        // error only if at least one bit arrived. An unknown command was
        // already counted this cycle and is not counted twice.
        if (cs_rise_q && !commit_now &&
            (state_q == ST_CMD || state_q == ST_PAYLOAD || state_q == ST_DISCARD)) begin
            if ((state_q == ST_CMD || state_q == ST_PAYLOAD) && abort_bits_q) begin
                err_now = 1'b1;
            end
            state_d    = ST_IDLE;
            byte_cnt_d = 3'd0;
        end

        if (err_now && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            cs_sync_q    <= '1;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            byte_done_q  <= 1'b0;
            cs_rise_q    <= 1'b0;
            frame_bits_q <= 1'b0;
            abort_bits_q <= 1'b0;
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 3'd0;
            cmd_q        <= 2'd0;
            voice_sh_q   <= 8'd0;
            tune_sh_q    <= 24'd0;
            note_q       <= 1'b0;
            voice_q      <= 8'd0;
            tune_q       <= 32'd0;
            vel_q        <= 7'd0;
            flag_dds_q   <= 1'b0;
            flag_adsr_q  <= 1'b0;
            err_q        <= 8'd0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_sync_q    <= cs_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_done_q  <= byte_done_d;
            cs_rise_q    <= cs_rise_d;
            frame_bits_q <= frame_bits_d;
            abort_bits_q <= abort_bits_d;
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            cmd_q        <= cmd_d;
            voice_sh_q   <= voice_sh_d;
            tune_sh_q    <= tune_sh_d;
            note_q       <= note_d;
            voice_q      <= voice_d;
            tune_q       <= tune_d;
            vel_q        <= vel_d;
            flag_dds_q   <= flag_dds_d;
            flag_adsr_q  <= flag_adsr_d;
            err_q        <= err_d;
        end
    end

    assign o_SPI_note_status = note_q;
    assign o_SPI_voice_index = voice_q;
    assign o_SPI_tuning_code = tune_q;
    assign o_SPI_velocity    = vel_q;
    assign o_SPI_flag_dds    = flag_dds_q;
    assign o_SPI_flag_adsr   = flag_adsr_q;
    assign o_err_count       = err_q;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_spi_voice_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_voice_cmd_decoder
//
// The bench drives SPI frames bit by bit. A behavioural model decides what
// each frame must do:
//   - it may commit a strobe, which is placed in exp_q with the cycle the
//     strobe is due;
//   - it may add an error count.
// A compare process checks the flags and data outputs on every cycle.
// Literal checks after each scenario pin down the model itself.
// -----------------------------------------------------------------------------
module tb_spi_voice_cmd_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;   // SCLK half period in i_clk cycles

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic mosi  = 1'b0;
    logic cs_n  = 1'b1;

    logic        note_status;
    logic [7:0]  voice_index;
    logic [31:0] tuning_code;
    logic [6:0]  velocity;
    logic        flag_dds;
    logic        flag_adsr;
    logic [7:0]  err_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_voice_cmd_decoder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_sclk            (sclk),
        .i_mosi            (mosi),
        .i_cs_n            (cs_n),
        .o_SPI_note_status (note_status),
        .o_SPI_voice_index (voice_index),
        .o_SPI_tuning_code (tuning_code),
        .o_SPI_velocity    (velocity),
        .o_SPI_flag_dds    (flag_dds),
        .o_SPI_flag_adsr   (flag_adsr),
        .o_err_count       (err_count),
        .o_dbg_state       (dbg_state)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;    // 1 tuning, 2 note on, 3 note off
        logic [7:0]  voice;
        logic [31:0] tune;
        logic [6:0]  vel;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  frm[8];
    logic [7:0]  m_voice = 8'd0;
    logic [31:0] m_tune  = 32'd0;
    logic [6:0]  m_vel   = 7'd0;
    logic        m_note  = 1'b0;
    int          m_err   = 0;
    logic        chk_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_frm(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        frm[0] = b0; frm[1] = b1; frm[2] = b2; frm[3] = b3;
        frm[4] = b4; frm[5] = b5; frm[6] = 8'h00; frm[7] = 8'h00;
    endtask

    function automatic int payload_len(input logic [7:0] cmd);
        case (cmd)
            8'h01:   return 5;
            8'h02:   return 2;
            8'h03:   return 1;
            default: return -1;
        endcase
    endfunction

    function automatic int err_inc(input int e);
        return (e < 255) ? e + 1 : 255;
    endfunction

    // ---------------- driver ----------------
    // Sends nbytes full bytes of frm, then tail_bits bits of frm[nbytes].
    // rel_on_last releases cs_n on the same edge as the final sclk rise.
    // hold keeps cs_n low at the end, for the reset-in-flight case.
    task automatic run_frame(input int nbytes, input int tail_bits,
                             input bit rel_on_last, input bit hold);
        int   need;
        int   nbits;
        exp_t nev;
        logic [7:0] b;
        need = -1;
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i <= nbytes; i++) begin
            nbits = (i < nbytes) ? 8 : tail_bits;
            b = frm[i];
            for (int k = 7; k >= 8 - nbits; k--) begin
                mosi = b[k];
                wait_clk(HALF);
                sclk = 1'b1;
                if (i == need && k == 0) begin
                    // Strobe due two cycles after the synchronised rise.
                    nev.cyc   = 32'(cyc + SYNC_STAGES + 2);
                    nev.kind  = frm[0][1:0];
                    nev.voice = frm[1];
                    nev.tune  = {frm[2], frm[3], frm[4], frm[5]};
                    nev.vel   = frm[2][6:0];
                    exp_q.push_back(nev);
                end
                if (rel_on_last && i == nbytes - 1 && k == 0) cs_n = 1'b1;
                wait_clk(HALF);
                sclk = 1'b0;
            end
            if (i == 0 && nbytes > 0) begin
                need = payload_len(frm[0]);
                if (need < 0) m_err = err_inc(m_err);
            end
        end
        if (!hold) begin
            if ((nbytes * 8 + tail_bits) > 0 &&
                (nbytes == 0 || (need > 0 && nbytes <= need))) begin
                m_err = err_inc(m_err);
            end
            if (!rel_on_last) begin
                wait_clk(HALF);
                cs_n = 1'b1;
            end
            wait_clk(3 * HALF);
        end
    endtask

    // ---------------- per-cycle scoreboard ----------------
    exp_t ev;
    logic e_dds;
    logic e_adsr;

    always @(negedge clk) begin
        if (chk_en) begin
            e_dds  = 1'b0;
            e_adsr = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev = exp_q.pop_front();
                check("strobe_missed_at_cycle", 32'(cyc), ev.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                m_voice = ev.voice;
                if (ev.kind == 2'd1) begin
                    m_tune = ev.tune;
                    e_dds  = 1'b1;
                end else if (ev.kind == 2'd2) begin
                    m_vel  = ev.vel;
                    m_note = 1'b1;
                    e_adsr = 1'b1;
                end else begin
                    m_vel  = 7'd0;
                    m_note = 1'b0;
                    e_adsr = 1'b1;
                end
            end
            check("flag_dds",    32'(flag_dds),    32'(e_dds));
            check("flag_adsr",   32'(flag_adsr),   32'(e_adsr));
            check("voice_index", 32'(voice_index), 32'(m_voice));
            check("tuning_code", tuning_code,      m_tune);
            check("velocity",    32'(velocity),    32'(m_vel));
            check("note_status", 32'(note_status), 32'(m_note));
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);
        check("reset_voice",  32'(voice_index), 32'h0);
        check("reset_tuning", tuning_code,      32'h0);
        check("reset_vel",    32'(velocity),    32'h0);
        check("reset_note",   32'(note_status), 32'h0);
        check("reset_err",    32'(err_count),   32'h0);
        chk_en = 1'b1;

        // 1: NOTE_ON voice 5 velocity 100
        set_frm(8'h02, 8'h05, 8'h64, 8'h00, 8'h00, 8'h00);
        run_frame(3, 0, 1'b0, 1'b0);
        check("s1_voice", 32'(voice_index), 32'd5);
        check("s1_vel",   32'(velocity),    32'd100);
        check("s1_note",  32'(note_status), 32'd1);
        check("s1_err",   32'(err_count),   32'(m_err));

        // 2: SET_TUNING voice 7 tune 0x12345678, note fields untouched
        set_frm(8'h01, 8'h07, 8'h12, 8'h34, 8'h56, 8'h78);
        run_frame(6, 0, 1'b0, 1'b0);
        check("s2_voice",  32'(voice_index), 32'd7);
        check("s2_tuning", tuning_code,      32'h12345678);
        check("s2_vel",    32'(velocity),    32'd100);
        check("s2_note",   32'(note_status), 32'd1);

        // 3: NOTE_OFF voice 5
        set_frm(8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(2, 0, 1'b0, 1'b0);
        check("s3_voice",  32'(voice_index), 32'd5);
        check("s3_vel",    32'(velocity),    32'd0);
        check("s3_note",   32'(note_status), 32'd0);
        check("s3_tuning", tuning_code,      32'h12345678);

        // 4: aborted SET_TUNING, then unknown command 0x7F
        set_frm(8'h01, 8'h07, 8'hAA, 8'h00, 8'h00, 8'h00);
        run_frame(3, 0, 1'b0, 1'b0);
        check("s4_abort_err", 32'(err_count),   32'd1);
        check("s4_tuning",    tuning_code,      32'h12345678);
        set_frm(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(1, 0, 1'b0, 1'b0);
        check("s4_unknown_err", 32'(err_count), 32'd2);

        // cs_n pulse with no bits is not an error
        run_frame(0, 0, 1'b0, 1'b0);
        check("empty_frame_err", 32'(err_count), 32'd2);

        // 5: trailing bytes after a commit are ignored
        set_frm(8'h02, 8'h05, 8'h64, 8'hFF, 8'hFF, 8'h00);
        run_frame(5, 0, 1'b0, 1'b0);
        check("s5_vel",  32'(velocity),  32'd100);
        check("s5_err",  32'(err_count), 32'd2);

        // final sclk rise and cs_n release on the same edge still commit
        set_frm(8'h03, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(2, 0, 1'b1, 1'b0);
        check("race_voice", 32'(voice_index), 32'd9);
        check("race_err",   32'(err_count),   32'(m_err));

        // abort in the middle of the command byte
        set_frm(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(0, 3, 1'b0, 1'b0);
        check("cmd_abort_err", 32'(err_count), 32'd3);

        // 6: reset after two payload bits of NOTE_ON
        set_frm(8'h02, 8'h05, 8'h64, 8'h00, 8'h00, 8'h00);
        run_frame(1, 2, 1'b0, 1'b1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        cs_n   = 1'b1;
        sclk   = 1'b0;
        wait_clk(4);
        check("s6_pending_strobes", 32'(exp_q.size()), 32'd0);
        m_voice = 8'd0; m_tune = 32'd0; m_vel = 7'd0; m_note = 1'b0; m_err = 0;
        rst_n = 1'b1;
        wait_clk(2);
        check("s6_voice", 32'(voice_index), 32'h0);
        check("s6_vel",   32'(velocity),    32'h0);
        check("s6_flags", 32'({flag_dds, flag_adsr}), 32'h0);
        check("s6_err",   32'(err_count),   32'h0);
        chk_en = 1'b1;
        // velocity byte 0xC8 has bit 7 set, which must be dropped -> 0x48
        set_frm(8'h02, 8'h0C, 8'hC8, 8'h00, 8'h00, 8'h00);
        run_frame(3, 0, 1'b0, 1'b0);
        check("s6b_voice", 32'(voice_index), 32'd12);
        check("s6b_vel",   32'(velocity),    32'h48);
        check("s6b_note",  32'(note_status), 32'd1);
        check("s6b_err",   32'(err_count),   32'd0);

        // error counter saturates at 0xFF
        set_frm(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int n = 0; n < 258; n++) begin
            run_frame(0, 1, 1'b0, 1'b0);
        end
        check("err_saturate",       32'(err_count), 32'hFF);
        check("err_saturate_model", 32'(err_count), 32'(m_err));
        check("voice_after_aborts", 32'(voice_index), 32'd12);

        wait_clk(4);
        check("strobes_outstanding", 32'(exp_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
